// File: rtl/fetch_pkg.sv
// Shared types and constants for the decode-side fetch queue.
package fetch_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    // addi x0,x0,0 presented to decode whenever the queue is empty
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fq_entry_t;

    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
        return pc + 64'd4;
    endfunction

endpackage

// File: rtl/fq_ptr_chk.sv
// Consistency checks between the queue pointers and the occupancy count.
module fq_ptr_chk #(
    parameter int  DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input logic          clk,
    input logic          rst,
    input logic [PW-1:0] wr_ptr,
    input logic [PW-1:0] rd_ptr,
    input logic [CW-1:0] count
);

    a_count_bound: assert property (@(posedge clk) disable iff (!rst)
        count <= CW'(DEPTH));

    // At full the pointers coincide, matching count modulo DEPTH
    a_ptr_diff: assert property (@(posedge clk) disable iff (!rst)
        PW'(wr_ptr - rd_ptr) == count[PW-1:0]);

endmodule

// File: rtl/fq_ptr_ctrl.sv
// Read/write pointers and occupancy for the fetch queue; flush wins over enq/deq.
module fq_ptr_ctrl #(
    parameter int  DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_f,
    input  logic          ready_d,
    input  logic          flush,
    output logic          ready_f,
    output logic          valid_d,
    output logic          enq,
    output logic [PW-1:0] wr_ptr,
    output logic [PW-1:0] rd_ptr,
    output logic [CW-1:0] count
);

    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          ready_f_s;
    logic          valid_d_s;
    logic          enq_s;
    logic          deq_s;

    // Handshake qualifiers derived from registered occupancy only
    always_comb begin
        ready_f_s = (count_r < CW'(DEPTH));
        valid_d_s = (count_r != {CW{1'b0}});
        enq_s     = valid_f & ready_f_s & ~flush;
        deq_s     = valid_d_s & ready_d & ~flush;
    end

    // Pointer and occupancy state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            // DEPTH is a power of two, so the pointers wrap on their own
            if (enq_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (deq_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({enq_s, deq_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign ready_f = ready_f_s;
    assign valid_d = valid_d_s;
    assign enq     = enq_s;
    assign wr_ptr  = wr_ptr_r;
    assign rd_ptr  = rd_ptr_r;
    assign count   = count_r;

endmodule

// File: rtl/fetch_queue.sv
// Decode-side circular FIFO of fetched (PC, Instr) pairs with valid/ready handshake and flush.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              DEPTH     = 4,
    parameter logic [ILEN-1:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       Valid_F,
    input  logic [XLEN-1:0]            PC_F,
    input  logic [ILEN-1:0]            Instr_F,
    output logic                       Ready_F,
    input  logic                       Flush,
    output logic                       Valid_D,
    input  logic                       Ready_D,
    output logic [XLEN-1:0]            PC_D,
    output logic [XLEN-1:0]            PCPlus4_D,
    output logic [ILEN-1:0]            Instr_D,
    output logic [$clog2(DEPTH):0]     Count
);

    localparam int PW = $clog2(DEPTH);

    fq_entry_t     mem_r [DEPTH];
    fq_entry_t     head_s;
    logic          enq_s;
    logic [PW-1:0] wr_ptr_s;
    logic [PW-1:0] rd_ptr_s;

    fq_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr_ctrl (
        .clk     (clk),
        .rst     (rst),
        .valid_f (Valid_F),
        .ready_d (Ready_D),
        .flush   (Flush),
        .ready_f (Ready_F),
        .valid_d (Valid_D),
        .enq     (enq_s),
        .wr_ptr  (wr_ptr_s),
        .rd_ptr  (rd_ptr_s),
        .count   (Count)
    );

    fq_ptr_chk #(.DEPTH(DEPTH)) u_ptr_chk (
        .clk    (clk),
        .rst    (rst),
        .wr_ptr (wr_ptr_s),
        .rd_ptr (rd_ptr_s),
        .count  (Count)
    );

    // Entry storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (enq_s) begin
            mem_r[wr_ptr_s] <= '{pc: PC_F, instr: Instr_F};
        end
    end

    // Head presentation: stale storage is masked to 0 / NOP while empty
    always_comb begin
        head_s = mem_r[rd_ptr_s];
        if (Valid_D) begin
            PC_D    = head_s.pc;
            Instr_D = head_s.instr;
        end else begin
            PC_D    = {XLEN{1'b0}};
            Instr_D = NOP_INSTR;
        end
    end

    assign PCPlus4_D = pc_plus4(PC_D);

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Decode-side receiver for the fetch stage's PC/Instr stream.
- Captures each fetched (PC, Instr) pair into a small circular FIFO and presents the oldest entry to the decode stage with a valid/ready handshake.
- Asserts back-pressure to fetch when full.
- Discards all buffered entries on a control-flow redirect, so fetch and decode are decoupled across decode stalls and taken branches.

Parameters:
- DEPTH, 4: number of entries; power of two, >= 2.
- XLEN, 64: PC width.
- ILEN, 32: instruction width.
- NOP_INSTR, 32'h00000013: value driven on Instr_D when empty (addi x0,x0,0).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- Valid_F  in  1  fetch presents a valid PC/Instr pair this cycle.
- PC_F  in  XLEN  PC of fetched instruction.
- Instr_F  in  ILEN  fetched instruction word.
- Ready_F  out  1  queue can accept an entry this cycle; fetch holds PC when 0.
- Flush  in  1  redirect (branch/jump taken); discard all entries.
- Valid_D  out  1  head entry valid for decode.
- Ready_D  in  1  decode consumes head this cycle.
- PC_D  out  XLEN  head PC.
- PCPlus4_D  out  XLEN  head PC + 4, computed on the dequeue side.
- Instr_D  out  ILEN  head instruction.
- Count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst=0, async):
  - wr_ptr=0, rd_ptr=0, count=0.
  - Valid_D=0, Ready_F=1, Count=0, PC_D=0, PCPlus4_D=4, Instr_D=NOP_INSTR.
  - Storage array is not reset.
  - Reset asserted mid-operation drops all entries immediately, with no clock edge needed.
- Ready_F = (count < DEPTH). This is registered-state based; there is no same-cycle full bypass.
- Enqueue fires when Valid_F && Ready_F && !Flush:
  - Write mem[wr_ptr] <= {PC_F, Instr_F}.
  - wr_ptr <= wr_ptr+1, wrapping modulo DEPTH.
- Dequeue fires when Valid_D && Ready_D && !Flush:
  - rd_ptr <= rd_ptr+1, wrapping modulo DEPTH.
- Count update:
  - count += enq - deq.
  - Simultaneous enq and deq (count between 1 and DEPTH-1) leaves count unchanged.
  - At full, deq proceeds and enq is rejected because Ready_F=0; count becomes DEPTH-1.
- Head outputs:
  - Valid_D = (count != 0).
  - PC_D and Instr_D are a combinational read of mem[rd_ptr] when Valid_D=1.
  - When empty: PC_D=0, Instr_D=NOP_INSTR.
  - PCPlus4_D = PC_D + 4, modulo 2^XLEN, so 64'hFFFF_FFFF_FFFF_FFFC wraps to 0.
- Latency: an entry enqueued on edge N is visible on Valid_D after edge N, i.e. one cycle enq-to-deq. There is no fall-through when empty.
- Flush has priority over everything:
  - On the edge: wr_ptr=rd_ptr=0, count=0.
  - Same-cycle enq and deq are both dropped.
  - Valid_D=0 the following cycle.
  - Ready_F is unaffected combinationally during the flush cycle.
- Error cases:
  - Valid_F while full: ignored; fetch must hold.
  - Ready_D while empty: no effect.
  - Pointers never diverge from count; assertions check count <= DEPTH and that ptr difference matches count.

Decomposition:
- Shared package fetch_pkg holds:
  - XLEN/ILEN localparams.
  - NOP_INSTR constant.
  - Typedef fq_entry_t (packed struct {pc, instr}).
- One sub-module: fq_ptr_ctrl, owning wr_ptr/rd_ptr/count and the full/empty/flush logic.
- Storage array and output muxing stay in fetch_queue.

Test Plan:
1. Reset, then 4 enqueues (PC 0x0, 0x4, 0x8, 0xC) with Ready_D=0 -> Count=4, Ready_F=0; a 5th Valid_F (PC 0x10) is dropped.
2. Continuing from 1, Ready_D=1 for 4 cycles -> PC_D sequence 0x0, 0x4, 0x8, 0xC; PCPlus4_D 0x4 .. 0x10; then Valid_D=0, Instr_D=0x00000013.
3. Steady stream with Valid_F=Ready_D=1 for 10 cycles at count=2 -> Count stays 2, all 10 PCs emerge in order across pointer wrap.
4. Count=3, Flush=1 with Valid_F=1 (PC 0x100) and Ready_D=1 in the same cycle -> next cycle Count=0, Valid_D=0; PC 0x100 never appears.
5. Count=4 with Valid_F=1 and Ready_D=1 -> Count=3, the new PC is not stored, and the head advances.
6. Drop rst to 0 between clock edges at count=2 -> outputs reset immediately; PC_F=64'hFFFF_FFFF_FFFF_FFFC enqueued afterward gives PCPlus4_D=0.
